key_cmd_decoder: RTL and testbench
==================================

# key_cmd_decoder

Converts the raw PS/2 scan-code byte stream from the keyboard driver into single-cycle game commands for the game controller. Parses set-2 make/break/extended prefixes, suppresses the keyboard's own typematic repeats, and generates its own auto-repeat for horizontal moves and soft drop. Sits between the PS/2 keyboard driver and the game FSM, in the main system clock domain.

## Interface
- REPEAT_DELAY, 25_000_000: cycles from first command to first auto-repeat (250 ms at 100 MHz)
- REPEAT_PERIOD, 5_000_000: cycles between subsequent auto-repeats
- PREFIX_TIMEOUT, 1_000_000: max cycles to wait for the byte following an E0/F0 prefix
- clk  in  1  system clock; one clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- data  in  8  scan-code byte from driver, valid when ready=1
- ready  in  1  one-cycle strobe per received byte
- cmd_valid  out  1  one-cycle pulse, cmd valid
- cmd  out  3  1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP, 6 PAUSE, 7 RESET; 0 never issued with cmd_valid
- key_held  out  3  bit0 LEFT, bit1 RIGHT, bit2 SOFT_DROP currently held

## Operation
- Key map, set-2: LEFT = E0 6B or 1C (A); RIGHT = E0 74 or 23 (D); ROTATE = E0 75 or 1D (W); SOFT_DROP = E0 72 or 1B (S); HARD_DROP = 29 (space); PAUSE = 4D (P); RESET = 2D (R). Other codes ignored.
- Parser FSM: IDLE, EXT (got E0), BRK (got F0), EXTBRK (got E0 F0).
  - IDLE: E0 -> EXT; F0 -> BRK; other byte = make of non-extended code -> IDLE.
  - EXT: F0 -> EXTBRK; E0 -> stay EXT; other = extended make -> IDLE.
  - BRK: any byte = break -> IDLE. EXTBRK: any byte = extended break -> IDLE.
  - Non-mapped codes still advance the FSM; they just produce no command.
  - In EXT/BRK/EXTBRK, a prefix-timeout counter runs; when PREFIX_TIMEOUT cycles elapse with no ready, return to IDLE and discard the prefix.
- Held tracking: a 7-bit held register, one bit per command. A make sets the bit. A break clears it.
  - A make of a key whose bit is already set produces no command. This suppresses keyboard typematic repeats.
  - A break never produces a command.
- Auto-repeat applies to LEFT, RIGHT, SOFT_DROP only.
  - Tracks one repeat key: the most recent repeatable make.
  - A new repeatable make replaces the repeat key and reloads the counter with REPEAT_DELAY.
  - When the counter expires: emit the repeat key's command and reload with REPEAT_PERIOD.
  - A break of the repeat key stops repeat. A break of any other key does not affect it.
- key_held = {held[SOFT_DROP], held[RIGHT], held[LEFT]}; A and left-arrow share one bit.

## Timing
- Reset: cmd_valid=0, cmd=0, key_held=0, FSM=IDLE, repeat inactive, counters 0.
- Latency:
  - ready with the final byte of a make at cycle N -> cmd_valid=1 at N+1, registered, for exactly one cycle.
  - cmd holds its value until the next cmd_valid.
  - Break at cycle N -> key_held updates at N+1.
- Repeat timing: first command at cycle C -> repeats at C+REPEAT_DELAY, C+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Simultaneous events:
  - A make command and a repeat expiry in the same cycle: the make wins; the repeat pulse is dropped and the counter reloads per the make rule.
  - A break of the repeat key in the same cycle as expiry: no repeat pulse is emitted.
- At most one cmd_valid per cycle; back-to-back ready strobes are accepted every cycle.
- rst mid-sequence (e.g. after E0) discards the partial code and clears held and repeat state; the next byte is parsed from IDLE.

## Test plan
Use REPEAT_DELAY=20, REPEAT_PERIOD=5, PREFIX_TIMEOUT=100 for these scenarios.
- Byte 2D at cycle 10 -> cmd_valid=1, cmd=7 at cycle 11 only; key_held=000.
- E0 then 6B (ready at 10, 20) -> cmd=1 pulse at 21; repeat pulses cmd=1 at 41, 46, 51. Then E0 F0 6B with the last byte at 53 -> key_held=000 at 54; no pulse at 56.
- Byte 1C three times (typematic) -> exactly one cmd=1 pulse; F0 1C then 1C again -> a second pulse.
- Hold LEFT (1C, pulse at 11), then press RIGHT (23) at cycle 15 -> cmd=2 at 16; repeats of cmd=2 at 36 and 41; no further cmd=1 pulses. Release 1C -> repeat of RIGHT continues.
- E0 then idle 100 cycles, then 6B -> parsed as non-extended 6B (unmapped), no pulse. F0 then 29 -> no pulse, FSM returns to IDLE.
- E0 then rst for 1 cycle, then 75 -> no pulse, outputs at reset values. Hold 1B across rst -> key_held=000 and repeat stopped.

Source files
------------

// File: rtl/key_cmd_decoder.sv
// PS/2 set-2 scan-code parser that turns make/break sequences into one-cycle game commands,
// suppresses keyboard typematic repeats and generates its own auto-repeat for moves and soft drop.
module key_cmd_decoder #(
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [2:0] key_held
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int PTO_W   = $clog2(PREFIX_TIMEOUT + 1);

    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [PTO_W-1:0] PTO_LAST      = PTO_W'(PREFIX_TIMEOUT - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_SOFT  = 3'd4;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t           state, state_nxt;
    logic [PTO_W-1:0] pto_cnt, pto_cnt_nxt;
    logic [6:0]       held, held_nxt;
    logic [2:0]       rep_key, rep_key_nxt;
    logic [RPT_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             cmd_valid_nxt;
    logic [2:0]       cmd_nxt;

    logic             is_make, is_brk, code_ext;
    logic [2:0]       key_id;
    logic [6:0]       key_oh;
    logic             make_cmd, repeatable;
    logic             rep_active, rep_expire, rep_stop, rep_fire;

    function automatic logic [2:0] map_code(input logic [7:0] code, input logic ext);
        logic [2:0] id;
        id = 3'd0;
        if (ext) begin
            case (code)
                8'h6B:   id = 3'd1;
                8'h74:   id = 3'd2;
                8'h75:   id = 3'd3;
                8'h72:   id = 3'd4;
                default: id = 3'd0;
            endcase
        end else begin
            case (code)
                8'h1C:   id = 3'd1;
                8'h23:   id = 3'd2;
                8'h1D:   id = 3'd3;
                8'h1B:   id = 3'd4;
                8'h29:   id = 3'd5;
                8'h4D:   id = 3'd6;
                8'h2D:   id = 3'd7;
                default: id = 3'd0;
            endcase
        end
        return id;
    endfunction

    always_comb begin
        state_nxt   = state;
        pto_cnt_nxt = '0;
        is_make     = 1'b0;
        is_brk      = 1'b0;
        code_ext    = 1'b0;

        case (state)
            IDLE: begin
                if (ready) begin
                    if (data == CODE_EXT)      state_nxt = EXT;
                    else if (data == CODE_BRK) state_nxt = BRK;
                    else                       is_make   = 1'b1;
                end
            end
            EXT: begin
                if (ready) begin
                    if (data == CODE_BRK) begin
                        state_nxt = EXTBRK;
                    end else if (data != CODE_EXT) begin
                        is_make   = 1'b1;
                        code_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            BRK: begin
                if (ready) begin
                    is_brk    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EXTBRK: begin
                if (ready) begin
                    is_brk    = 1'b1;
                    code_ext  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // An abandoned prefix must not glue itself onto a byte that arrives much later
        if (state != IDLE && !ready) begin
            if (pto_cnt == PTO_LAST) state_nxt   = IDLE;
            else                     pto_cnt_nxt = pto_cnt + PTO_W'(1);
        end

        key_id     = map_code(data, code_ext);
        key_oh     = (key_id == 3'd0) ? 7'd0 : (7'b1 << (key_id - 3'd1));
        make_cmd   = is_make && (key_id != 3'd0) && ((held & key_oh) == 7'd0);
        repeatable = (key_id == CMD_LEFT) || (key_id == CMD_RIGHT) || (key_id == CMD_SOFT);

        held_nxt = held;
        if (make_cmd)    held_nxt = held | key_oh;
        else if (is_brk) held_nxt = held & ~key_oh;

        rep_active  = (rep_key != 3'd0);
        rep_expire  = rep_active && (rep_cnt == '0);
        rep_stop    = is_brk && rep_active && (key_id == rep_key);
        rep_key_nxt = rep_key;
        rep_cnt_nxt = rep_cnt;
        if (make_cmd && repeatable) begin
            rep_key_nxt = key_id;
            rep_cnt_nxt = RPT_DELAY_LD;
        end else if (rep_stop) begin
            rep_key_nxt = 3'd0;
            rep_cnt_nxt = '0;
        end else if (rep_expire) begin
            rep_cnt_nxt = RPT_PERIOD_LD;
        end else if (rep_active) begin
            rep_cnt_nxt = rep_cnt - RPT_W'(1);
        end

        // A fresh make always takes the single output slot over a repeat
        rep_fire      = rep_expire && !make_cmd && !rep_stop;
        cmd_valid_nxt = make_cmd || rep_fire;
        cmd_nxt       = make_cmd ? key_id : (rep_fire ? rep_key : cmd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pto_cnt   <= '0;
            held      <= 7'd0;
            rep_key   <= 3'd0;
            rep_cnt   <= '0;
            cmd_valid <= 1'b0;
            cmd       <= 3'd0;
        end else begin
            state     <= state_nxt;
            pto_cnt   <= pto_cnt_nxt;
            held      <= held_nxt;
            rep_key   <= rep_key_nxt;
            rep_cnt   <= rep_cnt_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd       <= cmd_nxt;
        end
    end

    assign key_held = {held[3], held[1], held[0]};

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Bench for key_cmd_decoder: directed cycle-exact scenarios plus a random byte stream
// compared against an event-level reference model of the keyboard command rules.
module tb_key_cmd_decoder;

    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int PTO = 100;
    localparam int LEN = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] data;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [2:0] key_held;

    always #5 clk = ~clk;

    key_cmd_decoder #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .PREFIX_TIMEOUT(PTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .ready    (ready),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .key_held (key_held)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] stim_d[LEN];
    logic       stim_r[LEN];
    logic       stim_rst[LEN];
    logic [2:0] held_tr[LEN];
    logic [2:0] cmd_tr[LEN];
    int         obs_cyc[$];
    int         obs_cmd[$];
    int         exp_cyc[$];
    int         exp_cmd[$];

    task automatic clear_stim();
        for (int i = 0; i < LEN; i++) begin
            stim_d[i]   = 8'h00;
            stim_r[i]   = 1'b0;
            stim_rst[i] = 1'b0;
        end
        obs_cyc.delete();
        obs_cmd.delete();
        exp_cyc.delete();
        exp_cmd.delete();
    endtask

    task automatic put(input int t, input logic [7:0] b);
        stim_r[t] = 1'b1;
        stim_d[t] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        data  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Inputs for index t are applied before posedge t; outputs seen at index t come from posedge t-1.
    task automatic run_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            held_tr[t] = key_held;
            cmd_tr[t]  = cmd;
            if (cmd_valid === 1'b1) begin
                obs_cyc.push_back(t);
                obs_cmd.push_back(int'(cmd));
            end
            rst   = stim_rst[t];
            ready = stim_r[t];
            data  = stim_d[t];
        end
        ready = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic int keymap(input logic [7:0] code, input bit ext);
        if (ext) begin
            if (code == 8'h6B) return 1;
            if (code == 8'h74) return 2;
            if (code == 8'h75) return 3;
            if (code == 8'h72) return 4;
            return 0;
        end
        if (code == 8'h1C) return 1;
        if (code == 8'h23) return 2;
        if (code == 8'h1D) return 3;
        if (code == 8'h1B) return 4;
        if (code == 8'h29) return 5;
        if (code == 8'h4D) return 6;
        if (code == 8'h2D) return 7;
        return 0;
    endfunction

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        n_tests++;
        if (cmd !== 3'd0) begin n_fail++; $display("FAIL reset_cmd got %0d want 0", cmd); end
        n_tests++;
        if (key_held !== 3'b000) begin n_fail++; $display("FAIL reset_key_held got %b want 000", key_held); end
    endtask

    task automatic test_single_make();
        clear_stim();
        put(10, 8'h2D);
        exp_cyc = '{11};
        exp_cmd = '{7};
        apply_reset();
        run_cycles(30);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL single_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL single_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
        n_tests++;
        if (held_tr[11] !== 3'b000) begin n_fail++; $display("FAIL single_held got %b want 000", held_tr[11]); end
        n_tests++;
        if (cmd_tr[20] !== 3'd7) begin n_fail++; $display("FAIL single_cmd_hold got %0d want 7", cmd_tr[20]); end
    endtask

    task automatic test_ext_repeat();
        clear_stim();
        put(10, 8'hE0); put(20, 8'h6B);
        put(51, 8'hE0); put(52, 8'hF0); put(53, 8'h6B);
        exp_cyc = '{21, 41, 46, 51};
        exp_cmd = '{1, 1, 1, 1};
        apply_reset();
        run_cycles(70);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL ext_rep_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL ext_rep_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
        n_tests++;
        if (held_tr[53] !== 3'b001) begin n_fail++; $display("FAIL ext_rep_held53 got %b want 001", held_tr[53]); end
        n_tests++;
        if (held_tr[54] !== 3'b000) begin n_fail++; $display("FAIL ext_rep_held54 got %b want 000", held_tr[54]); end
    endtask

    task automatic test_typematic();
        clear_stim();
        put(10, 8'h1C); put(15, 8'h1C); put(20, 8'h1C);
        put(25, 8'hF0); put(26, 8'h1C); put(30, 8'h1C);
        exp_cyc = '{11, 31};
        exp_cmd = '{1, 1};
        apply_reset();
        run_cycles(45);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL typematic_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL typematic_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
        n_tests++;
        if (held_tr[27] !== 3'b000) begin n_fail++; $display("FAIL typematic_held27 got %b want 000", held_tr[27]); end
    endtask

    task automatic test_repeat_switch();
        clear_stim();
        put(10, 8'h1C); put(15, 8'h23);
        put(38, 8'hF0); put(39, 8'h1C);
        exp_cyc = '{11, 16, 36, 41, 46};
        exp_cmd = '{1, 2, 2, 2, 2};
        apply_reset();
        run_cycles(50);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL switch_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL switch_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
        n_tests++;
        if (held_tr[20] !== 3'b011) begin n_fail++; $display("FAIL switch_held20 got %b want 011", held_tr[20]); end
        n_tests++;
        if (held_tr[40] !== 3'b010) begin n_fail++; $display("FAIL switch_held40 got %b want 010", held_tr[40]); end
    endtask

    task automatic test_prefix_timeout();
        clear_stim();
        put(10, 8'hE0); put(111, 8'h6B);
        put(120, 8'hF0); put(121, 8'h29); put(125, 8'h29);
        put(130, 8'hE0); put(230, 8'h6B);
        exp_cyc = '{126, 231};
        exp_cmd = '{5, 1};
        apply_reset();
        run_cycles(240);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL timeout_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL timeout_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_stim();
        put(5, 8'h2D); put(10, 8'hE0);
        stim_rst[11] = 1'b1;
        put(13, 8'h75);
        put(20, 8'h1B);
        stim_rst[30] = 1'b1;
        exp_cyc = '{6, 21};
        exp_cmd = '{7, 4};
        apply_reset();
        run_cycles(60);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL rstmid_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL rstmid_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
        n_tests++;
        if (cmd_tr[10] !== 3'd7) begin n_fail++; $display("FAIL rstmid_cmd10 got %0d want 7", cmd_tr[10]); end
        n_tests++;
        if (cmd_tr[12] !== 3'd0) begin n_fail++; $display("FAIL rstmid_cmd12 got %0d want 0", cmd_tr[12]); end
        n_tests++;
        if (held_tr[25] !== 3'b100) begin n_fail++; $display("FAIL rstmid_held25 got %b want 100", held_tr[25]); end
        n_tests++;
        if (held_tr[31] !== 3'b000) begin n_fail++; $display("FAIL rstmid_held31 got %b want 000", held_tr[31]); end
    endtask

    task automatic test_back_to_back();
        clear_stim();
        put(10, 8'h1C); put(11, 8'h23); put(12, 8'h1D);
        put(13, 8'hE0); put(14, 8'h75);
        exp_cyc = '{11, 12, 13};
        exp_cmd = '{1, 2, 3};
        apply_reset();
        run_cycles(30);
        n_tests++;
        if (obs_cyc.size() != exp_cyc.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != exp_cyc[i] || obs_cmd[i] != exp_cmd[i]) begin
                n_fail++; $display("FAIL b2b_pulse%0d got cyc %0d cmd %0d want cyc %0d cmd %0d", i, obs_cyc[i], obs_cmd[i], exp_cyc[i], exp_cmd[i]);
            end
        end
    endtask

    task automatic test_random();
        bit         m_ext, m_brk;
        int         m_idle;
        bit         m_held[8];
        int         m_rep_key, m_rep_at;
        logic       e_valid;
        logic [2:0] e_cmd;
        int         id, quiet, pick;
        bit         made, due, stopped, reloaded;
        logic       r, rs;
        logic [7:0] d;

        m_ext = 0; m_brk = 0; m_idle = 0; m_rep_key = 0; m_rep_at = 0;
        foreach (m_held[k]) m_held[k] = 0;
        e_valid = 1'b0; e_cmd = 3'd0; quiet = 0;
        apply_reset();
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            n_tests++;
            if (cmd_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid t=%0d got %b want %b", t, cmd_valid, e_valid); end
            n_tests++;
            if (cmd !== e_cmd) begin n_fail++; $display("FAIL rnd_cmd t=%0d got %0d want %0d", t, cmd, e_cmd); end
            n_tests++;
            if (key_held !== {m_held[4], m_held[2], m_held[1]}) begin
                n_fail++; $display("FAIL rnd_held t=%0d got %b want %b", t, key_held, {m_held[4], m_held[2], m_held[1]});
            end

            rs = ($urandom_range(0, 599) == 0);
            if (quiet > 0) begin
                quiet--; r = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                quiet = $urandom_range(95, 105); r = 1'b0;
            end else begin
                r = ($urandom_range(0, 2) == 0);
            end
            pick = $urandom_range(0, 15);
            case (pick)
                0, 1:    d = 8'hE0;
                2, 3:    d = 8'hF0;
                4:       d = 8'h1C;
                5:       d = 8'h23;
                6:       d = 8'h1D;
                7:       d = 8'h1B;
                8:       d = 8'h29;
                9:       d = 8'h4D;
                10:      d = 8'h2D;
                11:      d = 8'h6B;
                12:      d = 8'h74;
                13:      d = 8'h75;
                14:      d = 8'h72;
                default: d = 8'($urandom);
            endcase
            rst = rs; ready = r; data = d;

            e_valid = 1'b0;
            if (rs) begin
                m_ext = 0; m_brk = 0; m_idle = 0; m_rep_key = 0;
                foreach (m_held[k]) m_held[k] = 0;
                e_cmd = 3'd0;
            end else begin
                due = (m_rep_key != 0) && (m_rep_at == t + 1);
                made = 0; stopped = 0; reloaded = 0;
                if (r) begin
                    if (m_brk) begin
                        id = keymap(d, m_ext);
                        if (id != 0) begin
                            m_held[id] = 0;
                            if (id == m_rep_key) begin m_rep_key = 0; stopped = 1; end
                        end
                        m_ext = 0; m_brk = 0;
                    end else if (d == 8'hE0) begin
                        m_ext = 1;
                    end else if (d == 8'hF0) begin
                        m_brk = 1;
                    end else begin
                        id = keymap(d, m_ext);
                        m_ext = 0;
                        if (id != 0 && !m_held[id]) begin
                            m_held[id] = 1; made = 1; e_valid = 1'b1; e_cmd = 3'(id);
                            if (id == 1 || id == 2 || id == 4) begin
                                m_rep_key = id; m_rep_at = t + 1 + RD; reloaded = 1;
                            end
                        end
                    end
                    m_idle = 0;
                end else if (m_ext || m_brk) begin
                    m_idle++;
                    if (m_idle >= PTO) begin m_ext = 0; m_brk = 0; m_idle = 0; end
                end
                if (due && !stopped) begin
                    if (!made) begin e_valid = 1'b1; e_cmd = 3'(m_rep_key); end
                    if (!reloaded) m_rep_at = m_rep_at + RP;
                end
            end
        end
        rst = 1'b0; ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        data  = 8'h00;
        test_reset();
        test_single_make();
        test_ext_repeat();
        test_typematic();
        test_repeat_switch();
        test_prefix_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
